// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } sched_state_t;

  localparam int unsigned FRAME_BYTES     = 3;
  localparam logic [3:0]  HDR_NIB_DEFAULT = 4'hA;

  function automatic logic [7:0] hdr_byte(input logic [3:0] nib, input logic [1:0] id);
    return {nib, 2'b00, id};
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin select: first set request above the pointer, wrapping at NUM_REQ.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [1:0]         i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [1:0]         o_id,
  output logic               o_valid
);

  logic [3:0] w_req_pad;
  logic [3:0] w_gnt_pad;
  logic [2:0] w_sum;
  logic       w_found;

  assign w_req_pad = 4'(i_req);
  assign o_gnt     = w_gnt_pad[NUM_REQ-1:0];
  assign o_valid   = w_found;

  always_comb begin
    w_gnt_pad = '0;
    o_id      = '0;
    w_found   = 1'b0;
    w_sum     = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      w_sum = {1'b0, i_ptr} + 3'(k);
      if (w_sum >= 3'(NUM_REQ)) begin
        w_sum = w_sum - 3'(NUM_REQ);
      end
      if (!w_found && w_req_pad[w_sum[1:0]]) begin
        w_found              = 1'b1;
        o_id                 = w_sum[1:0];
        w_gnt_pad[w_sum[1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter; each grant sends a
// 3-byte frame (header, data high, data low) over the trmt/tx_done handshake.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter logic [3:0]  HDR_NIB = HDR_NIB_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   frm_done,
  output logic                   busy,
  output logic [1:0]             grant_id,
  output logic                   trmt,
  output logic [7:0]             tx_data,
  input  logic                   tx_done
);

  sched_state_t r_state, w_state_nxt;

  logic [1:0]         r_ptr, w_ptr_nxt;
  logic [15:0]        r_word, w_word_nxt;
  logic [1:0]         r_byte_idx, w_byte_idx_nxt;
  logic [1:0]         r_grant_id, w_grant_id_nxt;
  logic [NUM_REQ-1:0] r_ack, w_ack_nxt;
  logic               r_frm_done, w_frm_done_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_trmt, w_trmt_nxt;
  logic [7:0]         r_tx_data, w_tx_data_nxt;

  logic [NUM_REQ-1:0] w_arb_gnt;
  logic [1:0]         w_arb_id;
  logic               w_arb_valid;
  logic [63:0]        w_data_pad;
  logic [15:0]        w_win_word;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_gnt   (w_arb_gnt),
    .o_id    (w_arb_id),
    .o_valid (w_arb_valid)
  );

  assign w_data_pad = 64'(req_data);
  assign w_win_word = w_data_pad[{w_arb_id, 4'b0000} +: 16];

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_word_nxt     = r_word;
    w_byte_idx_nxt = r_byte_idx;
    w_grant_id_nxt = r_grant_id;
    w_ack_nxt      = '0;
    w_frm_done_nxt = 1'b0;
    w_trmt_nxt     = 1'b0;
    w_tx_data_nxt  = r_tx_data;
    unique case (r_state)
      IDLE: begin
        if (w_arb_valid) begin
          w_state_nxt    = SEND;
          w_word_nxt     = w_win_word;
          w_grant_id_nxt = w_arb_id;
          w_ptr_nxt      = w_arb_id;
          w_byte_idx_nxt = 2'd0;
          w_trmt_nxt     = 1'b1;
          w_tx_data_nxt  = hdr_byte(HDR_NIB, w_arb_id);
          w_ack_nxt      = w_arb_gnt;
        end
      end
      SEND: begin
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          if (r_byte_idx < 2'(FRAME_BYTES - 1)) begin
            w_state_nxt    = SEND;
            w_byte_idx_nxt = r_byte_idx + 2'd1;
            w_trmt_nxt     = 1'b1;
            w_tx_data_nxt  = (r_byte_idx == 2'd0) ? r_word[15:8] : r_word[7:0];
          end else begin
            w_state_nxt    = IDLE;
            w_frm_done_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // Outputs are registered alongside the state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= 2'(NUM_REQ - 1);
      r_word     <= '0;
      r_byte_idx <= '0;
      r_grant_id <= '0;
      r_ack      <= '0;
      r_frm_done <= 1'b0;
      r_busy     <= 1'b0;
      r_trmt     <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_word     <= w_word_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_ack      <= w_ack_nxt;
      r_frm_done <= w_frm_done_nxt;
      r_busy     <= w_busy_nxt;
      r_trmt     <= w_trmt_nxt;
      r_tx_data  <= w_tx_data_nxt;
    end
  end

  assign ack      = r_ack;
  assign frm_done = r_frm_done;
  assign busy     = r_busy;
  assign grant_id = r_grant_id;
  assign trmt     = r_trmt;
  assign tx_data  = r_tx_data;

endmodule
